// File: rtl/unzigzag.sv
// Inverse zigzag reorder buffer: accepts 8x8 blocks in zigzag order and emits them
// in column-major natural order, double-buffered so one block fills while the other drains.
module unzigzag #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_in,
    output logic             rdy_out,
    input  logic [WIDTH-1:0] in,
    output logic             ena_out,
    input  logic             rdy_in,
    output logic [WIDTH-1:0] out
);

    // Zigzag position -> natural (column-major) element index.
    function automatic logic [5:0] zzIndex(input logic [5:0] p);
        logic [5:0] z;
        case (p)
            6'd0:  z = 6'd0;   6'd1:  z = 6'd8;   6'd2:  z = 6'd1;   6'd3:  z = 6'd2;
            6'd4:  z = 6'd9;   6'd5:  z = 6'd16;  6'd6:  z = 6'd24;  6'd7:  z = 6'd17;
            6'd8:  z = 6'd10;  6'd9:  z = 6'd3;   6'd10: z = 6'd4;   6'd11: z = 6'd11;
            6'd12: z = 6'd18;  6'd13: z = 6'd25;  6'd14: z = 6'd32;  6'd15: z = 6'd40;
            6'd16: z = 6'd33;  6'd17: z = 6'd26;  6'd18: z = 6'd19;  6'd19: z = 6'd12;
            6'd20: z = 6'd5;   6'd21: z = 6'd6;   6'd22: z = 6'd13;  6'd23: z = 6'd20;
            6'd24: z = 6'd27;  6'd25: z = 6'd34;  6'd26: z = 6'd41;  6'd27: z = 6'd48;
            6'd28: z = 6'd56;  6'd29: z = 6'd49;  6'd30: z = 6'd42;  6'd31: z = 6'd35;
            6'd32: z = 6'd28;  6'd33: z = 6'd21;  6'd34: z = 6'd14;  6'd35: z = 6'd7;
            6'd36: z = 6'd15;  6'd37: z = 6'd22;  6'd38: z = 6'd29;  6'd39: z = 6'd36;
            6'd40: z = 6'd43;  6'd41: z = 6'd50;  6'd42: z = 6'd57;  6'd43: z = 6'd58;
            6'd44: z = 6'd51;  6'd45: z = 6'd44;  6'd46: z = 6'd37;  6'd47: z = 6'd30;
            6'd48: z = 6'd23;  6'd49: z = 6'd31;  6'd50: z = 6'd38;  6'd51: z = 6'd45;
            6'd52: z = 6'd52;  6'd53: z = 6'd59;  6'd54: z = 6'd60;  6'd55: z = 6'd53;
            6'd56: z = 6'd46;  6'd57: z = 6'd39;  6'd58: z = 6'd47;  6'd59: z = 6'd54;
            6'd60: z = 6'd61;  6'd61: z = 6'd62;  6'd62: z = 6'd55;  default: z = 6'd63;
        endcase
        return z;
    endfunction

    logic [WIDTH-1:0] bank_q [0:127];
    logic [1:0]       full_q, full_d;
    logic             wrBank_q, wrBank_d;
    logic             rdBank_q, rdBank_d;
    logic [5:0]       wrCnt_q, wrCnt_d;
    logic [5:0]       rdCnt_q, rdCnt_d;
    logic             wrFire, rdFire;

    assign rdy_out = !full_q[wrBank_q];
    assign ena_out = full_q[rdBank_q];
    assign out     = ena_out ? bank_q[{rdBank_q, rdCnt_q}] : '0;
    assign wrFire  = ena_in && rdy_out;
    assign rdFire  = ena_out && rdy_in;

    // Writer and reader only ever touch the full flag of the bank they own, so both may complete together.
    always_comb begin
        full_d   = full_q;
        wrBank_d = wrBank_q;
        rdBank_d = rdBank_q;
        wrCnt_d  = wrCnt_q;
        rdCnt_d  = rdCnt_q;
        if (wrFire) begin
            wrCnt_d = wrCnt_q + 6'd1;
            if (wrCnt_q == 6'd63) begin
                full_d[wrBank_q] = 1'b1;
                wrBank_d         = !wrBank_q;
            end
        end
        if (rdFire) begin
            rdCnt_d = rdCnt_q + 6'd1;
            if (rdCnt_q == 6'd63) begin
                full_d[rdBank_q] = 1'b0;
                rdBank_d         = !rdBank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 2'b00;
            wrBank_q <= 1'b0;
            rdBank_q <= 1'b0;
            wrCnt_q  <= 6'd0;
            rdCnt_q  <= 6'd0;
        end else begin
            full_q   <= full_d;
            wrBank_q <= wrBank_d;
            rdBank_q <= rdBank_d;
            wrCnt_q  <= wrCnt_d;
            rdCnt_q  <= rdCnt_d;
        end
    end

    // Coefficient storage is deliberately left out of reset; the full flags gate its visibility.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            bank_q[{wrBank_q, zzIndex(wrCnt_q)}] <= in;
        end
    end

endmodule
